fast_vram_ctrl: RTL
===================

FAST_VRAM_CTRL -- requirements
Module: fast_vram_ctrl

Interface
REQ-001 Parameter STROBE_CYCLES, default 1: number of clocks nOE/nWE held low per access, legal 1..4.
REQ-002 CLK_24M  input  1  single clock; all logic on rising edge.
REQ-003 nRESET  input  1  reset, asynchronous assert, active-low.
REQ-004 VRAM_ADDR  output  11  SRAM address bus.
REQ-005 VRAM_DATA  inout  8  SRAM data bus; driven only during write accesses, else high-Z.
REQ-006 nVRAM_CE / nVRAM_OE / nVRAM_WE  output  1 each  SRAM strobes, active-low.
REQ-007 CPU_REQ  input  1  CPU access request, level, held until CPU_ACK.
REQ-008 CPU_WR  input  1  1 = write, 0 = read; sampled with grant.
REQ-009 CPU_WDATA  input  8  CPU write data; sampled with grant.
REQ-010 CPU_ADDR_WE / CPU_ADDR_IN  input  1 / 11  load CPU address register.
REQ-011 CPU_MOD_WE / CPU_MOD_IN  input  1 / 11  load CPU modulo register.
REQ-012 CPU_ACK / CPU_RDATA  output  1 / 8  one-clock completion pulse; read data, held until next CPU read.
REQ-013 VID_REQ / VID_ADDR  input  1 / 11  video fetch request (level) and address, sampled with grant.
REQ-014 VID_ACK / VID_RDATA  output  1 / 8  one-clock completion pulse; read data, held until next video read.

Function
REQ-015 FSM states IDLE, SETUP, STROBE, HOLD; IDLE->SETUP on any request, SETUP->STROBE after 1 clock, STROBE->HOLD after STROBE_CYCLES clocks, HOLD->IDLE after 1 clock.
REQ-016 Arbitration in IDLE only: VID_REQ wins over CPU_REQ when both high; no preemption of an access in progress.
REQ-017 Grant latches address, direction, write data and owner; later input changes do not affect the running access.
REQ-018 SETUP: VRAM_ADDR valid, nVRAM_CE=0, nVRAM_OE=nVRAM_WE=1; write data driven for writes.
REQ-019 STROBE: nVRAM_OE=0 (read) or nVRAM_WE=0 (write); never both low.
REQ-020 HOLD: both strobes high, nVRAM_CE=0, address and write data held; read data captured on STROBE->HOLD edge.
REQ-021 Owner ACK pulses high for exactly the HOLD clock; latency grant-clock to ACK = 2+STROBE_CYCLES clocks; access period 3+STROBE_CYCLES.
REQ-022 IDLE: nVRAM_CE=nVRAM_OE=nVRAM_WE=1, VRAM_DATA high-Z, VRAM_ADDR holds last value.
REQ-023 Request dropped mid-access: access completes and ACK still pulses.
REQ-024 Request still high in the cycle after ACK is treated as a new request.
REQ-025 Address and modulo registers 11-bit; all address arithmetic modulo 2048 (0x7FF+1 -> 0x000).

Reset
REQ-026 nRESET low forces: state IDLE, strobes 1, VRAM_DATA high-Z, VRAM_ADDR 0, ACKs 0, RDATAs 0x00, CPU address 0x000, modulo 0x001.
REQ-027 Reset mid-access aborts immediately with no ACK; first access after release starts from IDLE.

Configuration
REQ-028 Macro VRAM_AUTOINC_EN defined: after each CPU access, address register <= address + modulo on the HOLD clock; CPU_ADDR_WE in the same clock wins over increment.
REQ-029 VRAM_AUTOINC_EN undefined: address register changes only via CPU_ADDR_WE; CPU_MOD_WE/CPU_MOD_IN ignored, modulo register absent.

Verification
REQ-030 Reset, load addr 0x123, CPU write 0xA5 -> nVRAM_WE low STROBE_CYCLES clocks at ADDR 0x123, DATA 0xA5, CPU_ACK at grant+3 (default).
REQ-031 CPU read of 0x123 after REQ-030 -> nVRAM_OE low, CPU_RDATA=0xA5 with CPU_ACK, DATA high-Z throughout.
REQ-032 VID_REQ and CPU_REQ rise same clock -> video access first, CPU access starts next IDLE, ACKs 4 clocks apart.
REQ-033 AUTOINC_EN, addr 0x7FE, mod 0x003, two writes -> addresses 0x7FE then 0x001.
REQ-034 nRESET pulsed during STROBE of a write -> strobes high same edge, no ACK, registers at reset values.
REQ-035 STROBE_CYCLES=3 read -> nVRAM_OE low exactly 3 clocks, ACK at grant+5.

Source files
------------

// File: rtl/fast_vram_ctrl.sv
// Single-port 2Kx8 VRAM controller arbitrating video fetches and CPU accesses.
// Optional macro VRAM_AUTOINC_EN adds a modulo register and CPU address auto-increment.
module fast_vram_ctrl #(
  parameter int STROBE_CYCLES = 1
) (
  input  logic        CLK_24M,
  input  logic        nRESET,
  output logic [10:0] VRAM_ADDR,
  inout  wire  [7:0]  VRAM_DATA,
  output logic        nVRAM_CE,
  output logic        nVRAM_OE,
  output logic        nVRAM_WE,
  input  logic        CPU_REQ,
  input  logic        CPU_WR,
  input  logic [7:0]  CPU_WDATA,
  input  logic        CPU_ADDR_WE,
  input  logic [10:0] CPU_ADDR_IN,
  input  logic        CPU_MOD_WE,
  input  logic [10:0] CPU_MOD_IN,
  output logic        CPU_ACK,
  output logic [7:0]  CPU_RDATA,
  input  logic        VID_REQ,
  input  logic [10:0] VID_ADDR,
  output logic        VID_ACK,
  output logic [7:0]  VID_RDATA
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  localparam logic [2:0] LAST = 3'(STROBE_CYCLES - 1);

  state_t      state, nstate;
  logic [2:0]  cnt;
  logic        own_vid, wr_q, grant, strobe_end;
  logic [7:0]  wdata_q;
  logic [10:0] addr_q, cpu_addr;

  assign grant      = (state == IDLE) && (VID_REQ || CPU_REQ);
  assign strobe_end = (state == STROBE) && (cnt == LAST);

  always_comb begin
    nstate   = state;
    nVRAM_CE = 1'b1;
    nVRAM_OE = 1'b1;
    nVRAM_WE = 1'b1;
    CPU_ACK  = 1'b0;
    VID_ACK  = 1'b0;
    case (state)
      IDLE:   if (VID_REQ || CPU_REQ) nstate = SETUP;
      SETUP:  begin
        nVRAM_CE = 1'b0;
        nstate   = STROBE;
      end
      STROBE: begin
        nVRAM_CE = 1'b0;
        nVRAM_OE = wr_q;
        nVRAM_WE = !wr_q;
        if (cnt == LAST) nstate = HOLD;
      end
      HOLD:   begin
        nVRAM_CE = 1'b0;
        CPU_ACK  = !own_vid;
        VID_ACK  = own_vid;
        nstate   = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= nstate;
      cnt   <= (state == STROBE) ? cnt + 3'd1 : 3'd0;
    end
  end

  // Everything the running access needs is frozen at grant; video wins ties.
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      own_vid <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= 8'h00;
      addr_q  <= 11'h000;
    end else if (grant) begin
      own_vid <= VID_REQ;
      wr_q    <= !VID_REQ && CPU_WR;
      wdata_q <= CPU_WDATA;
      addr_q  <= VID_REQ ? VID_ADDR : cpu_addr;
    end
  end

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      CPU_RDATA <= 8'h00;
      VID_RDATA <= 8'h00;
    end else if (strobe_end && !wr_q) begin
      if (own_vid) VID_RDATA <= VRAM_DATA;
      else         CPU_RDATA <= VRAM_DATA;
    end
  end

`ifdef VRAM_AUTOINC_EN
  logic [10:0] mod_q;

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      mod_q    <= 11'h001;
      cpu_addr <= 11'h000;
    end else begin
      if (CPU_MOD_WE) mod_q <= CPU_MOD_IN;
      // An explicit address load beats the post-access increment.
      if (CPU_ADDR_WE)                      cpu_addr <= CPU_ADDR_IN;
      else if (state == HOLD && !own_vid)   cpu_addr <= cpu_addr + mod_q;
    end
  end
`else
  logic unused_mod;
  assign unused_mod = ^{CPU_MOD_WE, CPU_MOD_IN};

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET)          cpu_addr <= 11'h000;
    else if (CPU_ADDR_WE) cpu_addr <= CPU_ADDR_IN;
  end
`endif

  assign VRAM_ADDR = addr_q;
  assign VRAM_DATA = (state != IDLE && wr_q) ? wdata_q : 8'hzz;
endmodule
